// File: rtl/dino_pkg.sv
// dino_pkg
//   Shared types for the dinosaur game control path. The dinosaur state
//   register on the display side imports the same state encoding, so the
//   enum values below are fixed and must not be reordered.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    JUMP = 2'b10,
    DEAD = 2'b11
  } dino_state_e;

  // Width of a counter that holds values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dino_jump_ctrl_btn_debounce.sv
// btn_debounce
//   Two-flop synchronizer, level debouncer and rising-edge pulse for a raw
//   mechanical button.
//
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     btn_raw  in   raw asynchronous button, active-high
//     level    out  debounced button level
//     rise     out  one-cycle pulse on a 0->1 change of level
//
//   The accepted level changes only after DB_CYC consecutive synchronized
//   samples disagree with it; any agreeing sample restarts the count. A stable
//   edge on btn_raw therefore produces rise 2+DB_CYC cycles later.
module btn_debounce
  import dino_pkg::*;
#(
  parameter int unsigned DB_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;
  logic          differ;
  logic          flip;

  assign differ = (sync2_q != level_q);
  assign flip   = differ && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      // The counter also clears on the flip itself so that the next change
      // needs a fresh run of DB_CYC disagreeing samples.
      if (!differ || flip) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (flip) begin
        level_q <= ~level_q;
      end
      rise_q <= flip && !level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl
//   Game-side controller that produces the dinosaur state shown by the
//   display path: debounces the jump button, divides the clock into frame
//   ticks, runs the idle/run/jump/dead FSM and integrates jump physics once
//   per frame.
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     btn_jump     in   raw jump button, active-high
//     collide      in   collision flag, sampled every clk
//     restart      in   one-cycle restart pulse from game-over logic
//     dino_state   out  IDLE/RUN/JUMP/DEAD (dino_pkg encoding)
//     dino_height  out  height above ground, 0 = on ground
//     run_phase    out  leg animation phase, meaningful in RUN
//     frame_tick   out  one-cycle pulse per frame
//     jump_req     out  debounced rising-edge pulse of btn_jump
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for the first jump press; collisions ignored
//   RUN   | on the ground, legs animate every RUN_FRAMES frames
//   JUMP  | airborne, height/velocity integrated on each frame tick
//   DEAD  | frozen after a collision; restart or jump returns to IDLE
//
//   Event priority inside the FSM: collide > restart > jump_req > frame_tick.
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned FRAME_DIV  = 833333,
  parameter int unsigned DB_CYC     = 500000,
  parameter int          H_W        = 8,
  parameter int          JUMP_V0    = 12,
  parameter int          GRAVITY    = 1,
  parameter int unsigned RUN_FRAMES = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_jump,
  input  logic           collide,
  input  logic           restart,
  output logic [1:0]     dino_state,
  output logic [H_W-1:0] dino_height,
  output logic           run_phase,
  output logic           frame_tick,
  output logic           jump_req
);

  localparam int unsigned FW = cnt_width(FRAME_DIV);
  localparam int unsigned RW = cnt_width(RUN_FRAMES);
  localparam int          VW = H_W + 1;  // signed velocity
  localparam int          SW = H_W + 2;  // height + velocity without overflow

  localparam logic [FW-1:0]        FDIV_LAST = FW'(FRAME_DIV - 1);
  localparam logic [RW-1:0]        RUN_LAST  = RW'(RUN_FRAMES - 1);
  localparam logic [H_W-1:0]       H_MAX     = {H_W{1'b1}};
  localparam logic signed [VW-1:0] V0_S      = VW'(JUMP_V0);
  localparam logic signed [VW-1:0] G_S       = VW'(GRAVITY);

  // ---------------------------------------------------------------------
  // Button path
  // ---------------------------------------------------------------------
  logic btn_level;
  logic btn_rise;

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_jump),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  // ---------------------------------------------------------------------
  // Frame divider, free-running in every state
  // ---------------------------------------------------------------------
  logic [FW-1:0] fdiv_q;
  logic          frame_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdiv_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      if (fdiv_q == FDIV_LAST) begin
        fdiv_q <= '0;
      end else begin
        fdiv_q <= fdiv_q + 1'b1;
      end
      frame_tick_q <= (fdiv_q == FDIV_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Jump physics helpers
  // ---------------------------------------------------------------------
  dino_state_e           state_q;
  logic [H_W-1:0]        height_q;
  logic signed [VW-1:0]  vel_q;
  logic                  run_phase_q;
  logic [RW-1:0]         run_cnt_q;

  logic signed [SW-1:0]  sum_s;
  logic                  land;
  logic                  over;

  assign sum_s = $signed({2'b00, height_q}) + $signed({vel_q[VW-1], vel_q});
  // Landing when the new height would be zero or below.
  assign land  = sum_s[SW-1] || (sum_s == '0);
  // Positive and at or beyond 2^H_W: clamp to the top of the range.
  assign over  = !sum_s[SW-1] && sum_s[H_W];

  // ---------------------------------------------------------------------
  // Game FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      height_q    <= '0;
      vel_q       <= '0;
      run_phase_q <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_rise) begin
            state_q <= RUN;
          end
        end

        RUN: begin
          if (collide) begin
            state_q   <= DEAD;
            run_cnt_q <= '0;
          end else if (btn_rise) begin
            state_q   <= JUMP;
            vel_q     <= V0_S;
            run_cnt_q <= '0;
          end else if (frame_tick_q) begin
            if (run_cnt_q == RUN_LAST) begin
              run_cnt_q   <= '0;
              run_phase_q <= ~run_phase_q;
            end else begin
              run_cnt_q <= run_cnt_q + 1'b1;
            end
          end
        end

        JUMP: begin
          // A collision freezes height and velocity even on a landing tick.
          if (collide) begin
            state_q <= DEAD;
          end else if (frame_tick_q) begin
            if (land) begin
              height_q <= '0;
              vel_q    <= '0;
              state_q  <= RUN;
            end else begin
              height_q <= over ? H_MAX : sum_s[H_W-1:0];
              vel_q    <= vel_q - G_S;
            end
          end
        end

        DEAD: begin
          if (restart || btn_rise) begin
            state_q     <= IDLE;
            height_q    <= '0;
            vel_q       <= '0;
            run_phase_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dino_state  = state_q;
  assign dino_height = height_q;
  assign run_phase   = run_phase_q;
  assign frame_tick  = frame_tick_q;
  assign jump_req    = btn_rise;

  // The debounced level itself has no consumer beyond the edge pulse.
  logic unused_level;
  assign unused_level = btn_level;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
module tb_dino_jump_ctrl;

  localparam int FD = 4;
  localparam int DB = 3;
  localparam int HW = 8;
  localparam int V0 = 12;
  localparam int GR = 1;
  localparam int RF = 6;
  localparam int HMAX = (1 << HW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_jump = 1'b0;
  logic          collide = 1'b0;
  logic          restart = 1'b0;
  logic [1:0]    dino_state;
  logic [HW-1:0] dino_height;
  logic          run_phase;
  logic          frame_tick;
  logic          jump_req;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dino_jump_ctrl #(
    .FRAME_DIV  (FD),
    .DB_CYC     (DB),
    .H_W        (HW),
    .JUMP_V0    (V0),
    .GRAVITY    (GR),
    .RUN_FRAMES (RF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_jump    (btn_jump),
    .collide     (collide),
    .restart     (restart),
    .dino_state  (dino_state),
    .dino_height (dino_height),
    .run_phase   (run_phase),
    .frame_tick  (frame_tick),
    .jump_req    (jump_req)
  );

  // Behavioural model: edges since reset, button history, game variables.
  int m_edges;
  bit b_d1, b_d2;
  bit syn_hist[$];
  bit m_level, m_jreq, m_tick, m_phase;
  int m_state, m_h, m_v, m_run_ticks;

  // Observation bookkeeping for the directed checks.
  bit rec_en;
  int hq[$];
  bit prev_tick;
  int prev_state;
  int jr_cnt;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_edges = 0; b_d1 = 0; b_d2 = 0; syn_hist.delete();
    m_level = 0; m_jreq = 0; m_tick = 0; m_phase = 0;
    m_state = 0; m_h = 0; m_v = 0; m_run_ticks = 0;
    prev_tick = 0; prev_state = 0;
  endfunction

  // One clock edge: the game reacts to the pulses visible before the edge.
  function automatic void model_step(input bit b, input bit col, input bit rs);
    bit jr = m_jreq;
    bit tk = m_tick;
    bit syn;
    bit all_diff;
    case (m_state)
      0: if (jr) m_state = 1;
      1: begin
        if (col) begin m_state = 3; m_run_ticks = 0; end
        else if (jr) begin m_state = 2; m_v = V0; m_run_ticks = 0; end
        else if (tk) begin
          m_run_ticks++;
          if (m_run_ticks % RF == 0) m_phase = !m_phase;
        end
      end
      2: begin
        if (col) m_state = 3;
        else if (tk) begin
          if (m_h + m_v <= 0) begin m_h = 0; m_v = 0; m_state = 1; end
          else begin
            m_h = (m_h + m_v > HMAX) ? HMAX : m_h + m_v;
            m_v = m_v - GR;
          end
        end
      end
      default: if (rs || jr) begin m_state = 0; m_h = 0; m_v = 0; m_phase = 0; end
    endcase
    // Synchronized sample seen at this edge is the button from two edges ago.
    syn = b_d2; b_d2 = b_d1; b_d1 = b;
    syn_hist.push_back(syn);
    if (syn_hist.size() > DB) void'(syn_hist.pop_front());
    all_diff = (syn_hist.size() == DB);
    foreach (syn_hist[i]) if (syn_hist[i] == m_level) all_diff = 0;
    m_jreq = all_diff && !m_level;
    if (all_diff) m_level = !m_level;
    m_edges++;
    m_tick = (m_edges % FD == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step(btn_jump, collide, restart);
    @(negedge clk);
    if (rst_n) begin
      total++;
      if (dino_state !== 2'(m_state) || dino_height !== HW'(m_h) ||
          run_phase !== m_phase || frame_tick !== m_tick || jump_req !== m_jreq) begin
        bad++;
        $display("FAIL model t=%0t: dut st=%0d h=%0d ph=%0d tk=%0d jr=%0d want st=%0d h=%0d ph=%0d tk=%0d jr=%0d",
                 $time, dino_state, dino_height, run_phase, frame_tick, jump_req,
                 m_state, m_h, m_phase, m_tick, m_jreq);
      end
      if (rec_en && prev_tick && prev_state == 2) hq.push_back(int'(dino_height));
      prev_tick  = frame_tick;
      prev_state = int'(dino_state);
      if (jump_req) jr_cnt++;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0; btn_jump = 0; collide = 0; restart = 0;
    @(negedge clk);
    chk("rst_state", int'(dino_state), 0);
    chk("rst_height", int'(dino_height), 0);
    chk("rst_phase", int'(run_phase), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_jreq", int'(jump_req), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic press(input int n);
    btn_jump = 1;
    repeat (n) step();
    btn_jump = 0;
    repeat (8) step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int jr_at;
    int hold;
    bit second;
    int tg[$];
    bit last_ph;

    // Scenario 1: clean press latency and IDLE->RUN.
    reset_dut();
    jr_cnt = 0; jr_at = -1;
    btn_jump = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (jump_req && jr_at < 0) jr_at = i;
      if (i == 6) chk("s1_run_after_req", int'(dino_state), 1);
    end
    btn_jump = 0;
    repeat (10) step();
    chk("s1_latency", jr_at, 5);
    chk("s1_pulses", jr_cnt, 1);

    // Scenario 2: bouncing button never accepted.
    reset_dut();
    jr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      btn_jump = !btn_jump;
      step();
    end
    btn_jump = 0;
    repeat (10) step();
    chk("s2_pulses", jr_cnt, 0);
    chk("s2_idle", int'(dino_state), 0);

    // Scenario 3: full trajectory, with a second press mid-air ignored.
    reset_dut();
    press(6);
    chk("s3_in_run", int'(dino_state), 1);
    hq.delete(); rec_en = 1;
    btn_jump = 1; hold = 6; second = 0;
    for (int i = 0; i < 400 && hq.size() < 25; i++) begin
      step();
      if (hold > 0) begin
        hold--;
        if (hold == 0) btn_jump = 0;
      end
      if (!second && hq.size() == 8) begin
        second = 1; btn_jump = 1; hold = 6;
      end
    end
    btn_jump = 0;
    rec_en = 0;
    chk("s3_ticks", hq.size(), 25);
    if (hq.size() >= 25) begin
      chk("s3_t1", hq[0], 12);
      chk("s3_t2", hq[1], 23);
      chk("s3_t3", hq[2], 33);
      chk("s3_t12", hq[11], 78);
      chk("s3_t13", hq[12], 78);
      chk("s3_t24", hq[23], 12);
      chk("s3_t25", hq[24], 0);
    end
    chk("s3_landed_run", int'(dino_state), 1);
    repeat (8) step();

    // Scenario 4: collision at tick 5 freezes height; jump returns to IDLE.
    hq.delete(); rec_en = 1;
    btn_jump = 1; hold = 6;
    for (int i = 0; i < 100 && hq.size() < 5; i++) begin
      step();
      if (hold > 0) begin
        hold--;
        if (hold == 0) btn_jump = 0;
      end
    end
    btn_jump = 0;
    rec_en = 0;
    chk("s4_reached_t5", hq.size(), 5);
    chk("s4_h_t5", int'(dino_height), 50);
    collide = 1;
    step();
    collide = 0;
    chk("s4_dead", int'(dino_state), 3);
    chk("s4_frozen", int'(dino_height), 50);
    repeat (12) step();
    chk("s4_still_frozen", int'(dino_height), 50);
    press(6);
    chk("s4_idle", int'(dino_state), 0);
    chk("s4_h0", int'(dino_height), 0);

    // Scenario 5: collide with jump_req in RUN, then restart+collide in DEAD.
    press(6);
    chk("s5_run", int'(dino_state), 1);
    btn_jump = 1;
    for (int i = 0; i < 20 && !jump_req; i++) step();
    chk("s5_saw_req", int'(jump_req), 1);
    collide = 1;
    step();
    collide = 0;
    btn_jump = 0;
    chk("s5_dead", int'(dino_state), 3);
    chk("s5_h0", int'(dino_height), 0);
    repeat (8) step();
    chk("s5_stay_dead", int'(dino_state), 3);
    restart = 1; collide = 1;
    step();
    restart = 0; collide = 0;
    chk("s5_restart_idle", int'(dino_state), 0);

    // Scenario 6: run_phase period, then asynchronous reset mid-jump.
    press(6);
    last_ph = run_phase;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (run_phase != last_ph) tg.push_back(i);
      last_ph = run_phase;
    end
    chk("s6_toggles", (tg.size() >= 3) ? 1 : 0, 1);
    if (tg.size() >= 3) begin
      chk("s6_period_a", tg[1] - tg[0], 24);
      chk("s6_period_b", tg[2] - tg[1], 24);
    end
    btn_jump = 1;
    repeat (6) step();
    btn_jump = 0;
    repeat (30) step();
    chk("s6_jumping", int'(dino_state), 2);
    chk("s6_airborne", (dino_height != 0) ? 1 : 0, 1);
    #2 rst_n = 0;
    #1;
    chk("s6_async_state", int'(dino_state), 0);
    chk("s6_async_height", int'(dino_height), 0);
    chk("s6_async_phase", int'(run_phase), 0);
    chk("s6_async_tick", int'(frame_tick), 0);

    // Randomized play against the model.
    reset_dut();
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn_jump = ($urandom_range(0, 2) == 0);
        hold = $urandom_range(1, 12);
      end
      hold--;
      collide = ($urandom_range(0, 199) == 0);
      restart = (m_state == 3) && ($urandom_range(0, 9) == 0);
      step();
    end
    btn_jump = 0; collide = 0; restart = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
